// File: rtl/trdb_pkg.sv
// -----------------------------------------------------------------------------
// trdb_pkg
// Shared constants and types for the trace debugger packet streaming path.
//   TRDB_WORD_W : default output word width toward the uDMA
//   TRDB_PKT_W  : default maximum trace packet width
//   TRDB_LEN_W  : width of a packet length field able to hold 0..TRDB_PKT_W
//   trdb_pkt_t  : packet FIFO entry (payload + valid bit count)
// -----------------------------------------------------------------------------
package trdb_pkg;

    localparam int unsigned TRDB_WORD_W = 32;
    localparam int unsigned TRDB_PKT_W  = 64;
    localparam int unsigned TRDB_LEN_W  = $clog2(TRDB_PKT_W + 1);

    typedef struct packed {
        logic [TRDB_PKT_W-1:0] bits;
        logic [TRDB_LEN_W-1:0] len;
    } trdb_pkt_t;

endpackage

// File: rtl/trdb_fifo.sv
// -----------------------------------------------------------------------------
// trdb_fifo
// Generic synchronous FIFO with first-word fall-through read data.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and data (ignored while full)
//   pop_i/data_o  : read request (ignored while empty) and head entry
//   full_o/empty_o: occupancy flags
//   count_o       : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module trdb_fifo
    import trdb_pkg::*;
#(
    parameter int unsigned DATA_W = TRDB_PKT_W + TRDB_LEN_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic              full_s;
    logic              empty_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

    assign data_o  = mem_r[rd_ptr_r[AW-1:0]];
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign count_o = wr_ptr_r - rd_ptr_r;

    // Storage and pointer update; overflow/underflow requests are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (push_i && !full_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= data_i;
                wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_i && !empty_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/trdb_packet_stream.sv
// -----------------------------------------------------------------------------
// trdb_packet_stream
// Buffers variable-length trace packets in a FIFO, packs them LSB-first into a
// continuous bitstream and emits WORD_W-bit words over valid/ready.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   packet_bits_i/len_i  : packet payload (LSB-aligned) and valid bit count
//   packet_valid_i       : packet offered; accepted when packet_grant_o is high
//   packet_grant_o       : FIFO has room (independent of packet_valid_i)
//   flush_i              : zero-pad and emit any partial word once drained
//   word_o/word_valid_o  : output word and its valid
//   word_ready_i         : downstream accepts the word
//   fill_o               : bits held in the residual register
//   busy_o               : FIFO non-empty, residual non-empty or flush pending
// Optional build macro TRDB_STREAM_DROP_EN: grant is tied high, packets
// arriving on a full FIFO are dropped and counted (drop_cnt_o, saturating)
// and overflow_o goes sticky high on the first drop.
// -----------------------------------------------------------------------------
module trdb_packet_stream
    import trdb_pkg::*;
#(
    parameter int unsigned WORD_W = TRDB_WORD_W,
    parameter int unsigned PKT_W  = TRDB_PKT_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LEN_W  = $clog2(PKT_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [PKT_W-1:0]  packet_bits_i,
    input  logic [LEN_W-1:0]  packet_len_i,
    input  logic              packet_valid_i,
    output logic              packet_grant_o,
    input  logic              flush_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic [LEN_W:0]    fill_o,
    output logic              busy_o
`ifdef TRDB_STREAM_DROP_EN
    ,
    output logic [15:0]       drop_cnt_o,
    output logic              overflow_o
`endif
);

    localparam int unsigned RES_W  = WORD_W + PKT_W - 1;
    localparam int unsigned FILL_W = LEN_W + 1;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned ENT_W  = PKT_W + LEN_W;

    localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(WORD_W);
    localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(PKT_W);
    localparam logic [PKT_W-1:0]  PKT_ONE   = {{(PKT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [PKT_W-1:0] bits;
        logic [LEN_W-1:0] len;
    } pkt_entry_t;

    pkt_entry_t        pkt_in_s;
    pkt_entry_t        pkt_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [AW:0]       fifo_count_s;
    logic              push_s;
    logic              pop_s;
    logic              hs_s;
    logic              hold_s;
    logic [PKT_W-1:0]  mask_s;
    logic [RES_W-1:0]  ext_s;
    logic [RES_W-1:0]  shifted_s;
    logic [FILL_W-1:0] f2_s;
    logic [AW:0]       cnt_next_s;
    logic              empty_next_s;
    logic [RES_W-1:0]  residual_next_s;
    logic [FILL_W-1:0] fill_next_s;
    logic              pend_next_s;
    logic              valid_next_s;
    logic              busy_next_s;

    logic [RES_W-1:0]  residual_r;
    logic [FILL_W-1:0] fill_r;
    logic              pend_r;
    logic              word_valid_r;
    logic              busy_r;

    assign pkt_in_s = '{bits: packet_bits_i, len: packet_len_i};

    trdb_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_s),
        .data_i  (pkt_in_s),
        .pop_i   (pop_s),
        .data_o  (pkt_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

`ifdef TRDB_STREAM_DROP_EN
    logic        drop_s;
    logic [15:0] drop_cnt_r;
    logic        overflow_r;

    // Zero-length packets are never stored nor counted as drops.
    assign push_s         = packet_valid_i && (packet_len_i != {LEN_W{1'b0}}) && !fifo_full_s;
    assign drop_s         = packet_valid_i && (packet_len_i != {LEN_W{1'b0}}) && fifo_full_s;
    assign packet_grant_o = 1'b1;
    assign drop_cnt_o     = drop_cnt_r;
    assign overflow_o     = overflow_r;

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_r <= 16'h0000;
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != 16'hFFFF) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end
        end
    end
`else
    logic grant_r;

    // grant_r mirrors !full of the current FIFO state; a len==0 packet is granted but not written.
    assign push_s         = packet_valid_i && grant_r && (packet_len_i != {LEN_W{1'b0}});
    assign packet_grant_o = grant_r;

    // Grant is registered from the FIFO occupancy that follows this edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_r <= 1'b0;
        end else begin
            grant_r <= (cnt_next_s != (AW+1)'(DEPTH));
        end
    end
`endif

    // Next-state for the residual register, pop decision and registered flags.
    always_comb begin
        hs_s   = word_valid_r && word_ready_i;
        // A presented word that is not taken must not change, so loading is frozen.
        hold_s = word_valid_r && !word_ready_i;

        if (pkt_head_s.len >= LEN_FULL) begin
            mask_s = {PKT_W{1'b1}};
        end else begin
            mask_s = (PKT_ONE << pkt_head_s.len) - PKT_ONE;
        end
        ext_s = {{(RES_W-PKT_W){1'b0}}, pkt_head_s.bits & mask_s};

        if (hs_s) begin
            shifted_s = residual_r >> WORD_W;
            if (fill_r >= WORD_FILL) begin
                f2_s = fill_r - WORD_FILL;
            end else begin
                f2_s = {FILL_W{1'b0}};
            end
        end else begin
            shifted_s = residual_r;
            f2_s      = fill_r;
        end

        if (!fifo_empty_s && !hold_s && (f2_s < WORD_FILL)) begin
            pop_s           = 1'b1;
            residual_next_s = shifted_s | (ext_s << f2_s);
            fill_next_s     = f2_s + {1'b0, pkt_head_s.len};
        end else begin
            pop_s           = 1'b0;
            residual_next_s = shifted_s;
            fill_next_s     = f2_s;
        end

        cnt_next_s   = fifo_count_s + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        empty_next_s = (cnt_next_s == {(AW+1){1'b0}});
        // A flush with nothing buffered falls straight through this clear term.
        pend_next_s  = (pend_r || flush_i) && !(empty_next_s && (fill_next_s == {FILL_W{1'b0}}));

        if (hold_s) begin
            valid_next_s = 1'b1;
        end else begin
            valid_next_s = (fill_next_s >= WORD_FILL) ||
                           (pend_next_s && empty_next_s && (fill_next_s != {FILL_W{1'b0}}));
        end

        busy_next_s = !empty_next_s || (fill_next_s != {FILL_W{1'b0}}) || pend_next_s;
    end

    // Alignment state and registered output flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            residual_r   <= {RES_W{1'b0}};
            fill_r       <= {FILL_W{1'b0}};
            pend_r       <= 1'b0;
            word_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            residual_r   <= residual_next_s;
            fill_r       <= fill_next_s;
            pend_r       <= pend_next_s;
            word_valid_r <= valid_next_s;
            busy_r       <= busy_next_s;
        end
    end

    // Bits above fill are always zero, so a flushed partial word is zero-padded.
    assign word_o       = residual_r[WORD_W-1:0];
    assign word_valid_o = word_valid_r;
    assign fill_o       = fill_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_trdb_packet_stream.sv
// -----------------------------------------------------------------------------
// tb_trdb_packet_stream
// Directed bench for trdb_packet_stream at default parameters
// (WORD_W=32, PKT_W=64, DEPTH=4). Optional-feature checks are compiled in when
// TRDB_STREAM_DROP_EN is defined.
// -----------------------------------------------------------------------------
module tb_trdb_packet_stream;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [63:0] packet_bits_i;
    logic [6:0]  packet_len_i;
    logic        packet_valid_i;
    logic        packet_grant_o;
    logic        flush_i;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i;
    logic [7:0]  fill_o;
    logic        busy_o;
`ifdef TRDB_STREAM_DROP_EN
    logic [15:0] drop_cnt_o;
    logic        overflow_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] words_q [$];

    typedef struct {
        logic [63:0] b0;
        logic [6:0]  l0;
        logic [63:0] b1;
        logic [6:0]  l1;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  fill;
        logic [31:0] fw;
    } vec_t;

    vec_t vecs [6];

    trdb_packet_stream dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .packet_bits_i  (packet_bits_i),
        .packet_len_i   (packet_len_i),
        .packet_valid_i (packet_valid_i),
        .packet_grant_o (packet_grant_o),
        .flush_i        (flush_i),
        .word_o         (word_o),
        .word_valid_o   (word_valid_o),
        .word_ready_i   (word_ready_i),
        .fill_o         (fill_o),
        .busy_o         (busy_o)
`ifdef TRDB_STREAM_DROP_EN
        ,
        .drop_cnt_o     (drop_cnt_o),
        .overflow_o     (overflow_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Record every accepted output word.
    always @(posedge clk_i) begin
        if (word_valid_o && word_ready_i) words_q.push_back(word_o);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_pkt(input logic [63:0] bits, input logic [6:0] len);
        int budget = 0;
        packet_valid_i = 1'b1;
        packet_bits_i  = bits;
        packet_len_i   = len;
        while (!packet_grant_o && budget < 50) begin
            @(negedge clk_i);
            budget++;
        end
        if (budget >= 50) chk("grant_timeout", 64'(packet_grant_o), 64'h1);
        @(negedge clk_i);
        packet_valid_i = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
    endtask

    function automatic logic [63:0] seq_pkt(input int i);
        return {32'hB000_0000 + 32'(2*i+1), 32'hB000_0000 + 32'(2*i)};
    endfunction

    initial begin
        logic [31:0] got;
        int idx;
        int gaps;

        vecs[0] = '{64'h0000_00AB_1234_5678, 7'd40, 64'hFFFF_FFFF_FFFF_FFFF, 7'd0, 1, 32'h1234_5678, 32'h0, 8'd8, 32'h0000_00AB};
        vecs[1] = '{64'h0000_0000_0000_BEEF, 7'd16, 64'h0000_0000_0000_CAFE, 7'd16, 1, 32'hCAFE_BEEF, 32'h0, 8'd0, 32'h0};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 7'd64, 64'h0000_0000_0000_005A, 7'd8, 2, 32'h89AB_CDEF, 32'h0123_4567, 8'd8, 32'h0000_005A};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd12, 64'hDEAD_BEEF_FF12_3456, 7'd24, 1, 32'h2345_6FFF, 32'h0, 8'd4, 32'h0000_0001};
        vecs[4] = '{64'h0000_0000_0000_0001, 7'd1, 64'hFFFF_FFFF_FFFF_FFFE, 7'd1, 0, 32'h0, 32'h0, 8'd2, 32'h0000_0001};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_0000, 7'd32, 64'h0, 7'd0, 1, 32'hFFFF_0000, 32'h0, 8'd0, 32'h0};

        rst_ni = 1'b0;
        packet_bits_i = 64'h0;
        packet_len_i = 7'd0;
        packet_valid_i = 1'b0;
        flush_i = 1'b0;
        word_ready_i = 1'b1;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_word_valid", 64'(word_valid_o), 64'h0);
        chk("rst_word", 64'(word_o), 64'h0);
        chk("rst_fill", 64'(fill_o), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
`ifdef TRDB_STREAM_DROP_EN
        chk("rst_grant", 64'(packet_grant_o), 64'h1);
        chk("rst_drop_cnt", 64'(drop_cnt_o), 64'h0);
        chk("rst_overflow", 64'(overflow_o), 64'h0);
`else
        chk("rst_grant", 64'(packet_grant_o), 64'h0);
`endif
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("grant_after_rst", 64'(packet_grant_o), 64'h1);

        // Latency: accepted at edge k, word valid after edge k+1
        packet_valid_i = 1'b1;
        packet_bits_i = 64'h0000_0000_5555_AAAA;
        packet_len_i = 7'd32;
        @(negedge clk_i);
        packet_valid_i = 1'b0;
        chk("lat_valid_k", 64'(word_valid_o), 64'h0);
        chk("lat_busy_k", 64'(busy_o), 64'h1);
        @(negedge clk_i);
        chk("lat_valid_k1", 64'(word_valid_o), 64'h1);
        chk("lat_word_k1", 64'(word_o), 64'h5555_AAAA);
        @(negedge clk_i);
        chk("lat_consumed", 64'(word_valid_o), 64'h0);
        repeat (2) @(negedge clk_i);

        // Table-driven packing vectors, each ended by a flush
        for (int v = 0; v < 6; v++) begin
            words_q.delete();
            send_pkt(vecs[v].b0, vecs[v].l0);
            send_pkt(vecs[v].b1, vecs[v].l1);
            repeat (6) @(negedge clk_i);
            chk($sformatf("v%0d_nwords", v), 64'(words_q.size()), 64'(vecs[v].nw));
            for (int i = 0; i < vecs[v].nw; i++) begin
                got = (words_q.size() > i) ? words_q[i] : {32{1'bx}};
                chk($sformatf("v%0d_word%0d", v, i), 64'(got), (i == 0) ? 64'(vecs[v].w0) : 64'(vecs[v].w1));
            end
            chk($sformatf("v%0d_fill", v), 64'(fill_o), 64'(vecs[v].fill));
            chk($sformatf("v%0d_nowordpreflush", v), 64'(word_valid_o), 64'h0);
            words_q.delete();
            pulse_flush();
            repeat (4) @(negedge clk_i);
            chk($sformatf("v%0d_nflush", v), 64'(words_q.size()), (vecs[v].fill != 8'd0) ? 64'h1 : 64'h0);
            if (vecs[v].fill != 8'd0) begin
                got = (words_q.size() > 0) ? words_q[0] : {32{1'bx}};
                chk($sformatf("v%0d_flushword", v), 64'(got), 64'(vecs[v].fw));
            end
            chk($sformatf("v%0d_busy_end", v), 64'(busy_o), 64'h0);
            chk($sformatf("v%0d_fill_end", v), 64'(fill_o), 64'h0);
        end

        // Zero-length packet: granted, never stored
        words_q.delete();
        packet_valid_i = 1'b1;
        packet_bits_i = 64'hFFFF_FFFF_FFFF_FFFF;
        packet_len_i = 7'd0;
        chk("len0_grant", 64'(packet_grant_o), 64'h1);
        @(negedge clk_i);
        packet_valid_i = 1'b0;
        chk("len0_busy_a", 64'(busy_o), 64'h0);
        repeat (2) @(negedge clk_i);
        chk("len0_busy_b", 64'(busy_o), 64'h0);
        chk("len0_nwords", 64'(words_q.size()), 64'h0);

`ifndef TRDB_STREAM_DROP_EN
        // Backpressure: five 64-bit packets with ready low fill residual + FIFO
        word_ready_i = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (idx < 5) begin
                packet_valid_i = 1'b1;
                packet_bits_i = seq_pkt(idx);
                packet_len_i = 7'd64;
                if (packet_grant_o) idx++;
            end else begin
                packet_valid_i = 1'b0;
            end
        end
        chk("bp_accepted", 64'(idx), 64'd5);
        chk("bp_grant_low", 64'(packet_grant_o), 64'h0);
        chk("bp_valid", 64'(word_valid_o), 64'h1);
        chk("bp_word_hold_a", 64'(word_o), 64'hB000_0000);
        repeat (3) @(negedge clk_i);
        chk("bp_word_hold_b", 64'(word_o), 64'hB000_0000);
        words_q.delete();
        word_ready_i = 1'b1;
        gaps = 0;
        for (int i = 0; i < 10; i++) begin
            if (!word_valid_o) gaps++;
            @(negedge clk_i);
        end
        chk("bp_gaps", 64'(gaps), 64'd0);
        chk("bp_nwords", 64'(words_q.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            got = (words_q.size() > i) ? words_q[i] : {32{1'bx}};
            chk($sformatf("bp_word%0d", i), 64'(got), 64'(32'hB000_0000 + 32'(i)));
        end
        chk("bp_drained", 64'(word_valid_o), 64'h0);
        chk("bp_grant_back", 64'(packet_grant_o), 64'h1);
`endif

        // Reset mid-data: 24 bits held as a flushed word, 2 packets queued behind it
        word_ready_i = 1'b0;
        send_pkt(64'h0000_0000_00C0_FFEE, 7'd24);
        repeat (2) @(negedge clk_i);
        chk("mid_fill24", 64'(fill_o), 64'd24);
        chk("mid_novalid", 64'(word_valid_o), 64'h0);
        pulse_flush();
        chk("mid_flush_valid", 64'(word_valid_o), 64'h1);
        send_pkt(64'h11, 7'd8);
        send_pkt(64'h22, 7'd8);
        @(negedge clk_i);
        chk("mid_hold_fill", 64'(fill_o), 64'd24);
        chk("mid_hold_word", 64'(word_o), 64'h00C0_FFEE);
        chk("mid_hold_valid", 64'(word_valid_o), 64'h1);
        words_q.delete();
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(word_valid_o), 64'h0);
        chk("mid_rst_fill", 64'(fill_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("mid_grant", 64'(packet_grant_o), 64'h1);
        chk("mid_busy", 64'(busy_o), 64'h0);
        word_ready_i = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("mid_discarded", 64'(words_q.size()), 64'h0);

`ifdef TRDB_STREAM_DROP_EN
        // Drop: residual already holds one packet, then 6 offered -> 4 stored, 2 dropped
        word_ready_i = 1'b0;
        send_pkt(seq_pkt(0), 7'd64);
        repeat (2) @(negedge clk_i);
        for (int i = 1; i <= 6; i++) begin
            packet_valid_i = 1'b1;
            packet_bits_i = seq_pkt(i);
            packet_len_i = 7'd64;
            @(negedge clk_i);
        end
        packet_valid_i = 1'b0;
        @(negedge clk_i);
        chk("drop_cnt", 64'(drop_cnt_o), 64'd2);
        chk("drop_overflow", 64'(overflow_o), 64'h1);
        chk("drop_grant", 64'(packet_grant_o), 64'h1);
        words_q.delete();
        word_ready_i = 1'b1;
        repeat (14) @(negedge clk_i);
        chk("drop_nwords", 64'(words_q.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            got = (words_q.size() > i) ? words_q[i] : {32{1'bx}};
            chk($sformatf("drop_word%0d", i), 64'(got), 64'(32'hB000_0000 + 32'(i)));
        end
        chk("drop_overflow_sticky", 64'(overflow_o), 64'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
